// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: valid/ready memory sequencer with MFC timeout, bounded retry and a back-pressured response channel.
module mem_access_ctrl #(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_we,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_wdata,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_data,
  output logic          o_rsp_err,
  output logic          o_mem_en,
  output logic          o_mem_rw,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mfc,
  output logic          o_busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RETRY, S_RESP} state_t;
  state_t        r_state, w_next;
  logic [TW-1:0] r_tcnt;
  logic [RW-1:0] r_rcnt;
  logic          w_tout, w_retry;
  assign w_tout      = !i_mfc && r_tcnt == T_LAST;
  assign w_retry     = r_rcnt < R_MAX;
  assign o_req_ready = r_state == S_IDLE;
  assign o_busy      = r_state != S_IDLE;
  assign o_mem_en    = r_state == S_WAIT;
  assign o_rsp_valid = r_state == S_RESP;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_req_valid ? S_WAIT : S_IDLE;
      S_WAIT:  w_next = i_mfc ? S_RESP : w_tout ? (w_retry ? S_RETRY : S_RESP) : S_WAIT;
      S_RETRY: w_next = S_WAIT;
      S_RESP:  w_next = i_rsp_ready ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  // mfc has priority over a same-cycle timeout; counters saturate by construction
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_tcnt      <= '0;
      r_rcnt      <= '0;
      o_mem_rw    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
    end else if (r_state == S_IDLE && i_req_valid) begin
      r_tcnt      <= '0;
      r_rcnt      <= '0;
      o_mem_rw    <= ~i_req_we;
      o_mem_addr  <= i_req_addr;
      o_mem_wdata <= i_req_wdata;
    end else if (r_state == S_WAIT) begin
      if (i_mfc) begin
        o_rsp_data <= o_mem_rw ? i_mem_rdata : '0;
        o_rsp_err  <= 1'b0;
      end else if (w_tout) begin
        r_tcnt <= '0;
        if (w_retry) r_rcnt <= r_rcnt + 1'b1;
        else begin
          o_rsp_data <= '0;
          o_rsp_err  <= 1'b1;
        end
      end else r_tcnt <= r_tcnt + 1'b1;
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized accesses checked against a per-access expected mem_en trace.
module tb_mem_access_ctrl;
  localparam int TO = 4;
  localparam int MR = 2;
  logic        clk = 1'b0;
  logic        i_rst_n, i_req_valid, i_req_we, i_rsp_ready, i_mfc;
  logic [15:0] i_req_addr, i_req_wdata, i_mem_rdata;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_mem_en, o_mem_rw, o_busy;
  logic [15:0] o_rsp_data, o_mem_addr, o_mem_wdata;
  int          checks = 0, errors = 0;
  mem_access_ctrl #(.DW(16), .AW(16), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_err(o_rsp_err), .o_mem_en(o_mem_en), .o_mem_rw(o_mem_rw), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mfc(i_mfc), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  // ha/hc: attempt and WAIT cycle where mfc arrives (ha>MR means never); rd: extra cycles rsp_ready stays low
  task automatic access(input logic we, input logic [15:0] addr, wdata, rdata, input int ha, hc, rd);
    logic        en_q[$];
    int          hit;
    logic        err;
    logic [15:0] exp_d;
    hit = -1;
    for (int a = 0; a <= MR && hit < 0; a++) begin
      for (int c = 0; c < TO && hit < 0; c++) begin
        en_q.push_back(1'b1);
        if (a == ha && c == hc) hit = en_q.size() - 1;
      end
      if (hit < 0 && a < MR) en_q.push_back(1'b0);
    end
    err   = hit < 0;
    exp_d = (err || we) ? 16'h0 : rdata;
    @(negedge clk);
    chk("idle_ready", 16'(o_req_ready), 16'd1);
    chk("idle_busy", 16'(o_busy), 16'd0);
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wdata = wdata; i_mfc = 1'b0;
    foreach (en_q[i]) begin
      @(negedge clk);
      i_req_valid = 1'b0;
      i_req_addr  = 16'($urandom);
      i_req_wdata = 16'($urandom);
      chk($sformatf("mem_en[%0d]", i), 16'(o_mem_en), 16'(en_q[i]));
      chk("busy", 16'(o_busy), 16'd1);
      chk("rsp_valid_early", 16'(o_rsp_valid), 16'd0);
      chk("req_ready_busy", 16'(o_req_ready), 16'd0);
      chk("mem_addr", o_mem_addr, addr);
      chk("mem_rw", 16'(o_mem_rw), 16'(!we));
      chk("mem_wdata", o_mem_wdata, wdata);
      i_mfc       = (i == hit) || !en_q[i];
      i_mem_rdata = (i == hit) ? rdata : 16'($urandom);
    end
    for (int k = 0; k <= rd; k++) begin
      @(negedge clk);
      i_mfc       = 1'($urandom);
      i_mem_rdata = 16'($urandom);
      chk("rsp_valid", 16'(o_rsp_valid), 16'd1);
      chk("rsp_data", o_rsp_data, exp_d);
      chk("rsp_err", 16'(o_rsp_err), 16'(err));
      chk("resp_req_ready", 16'(o_req_ready), 16'd0);
      chk("resp_mem_en", 16'(o_mem_en), 16'd0);
      i_req_valid = 1'b1;
      i_rsp_ready = (k == rd);
    end
    @(negedge clk);
    chk("after_rsp_valid", 16'(o_rsp_valid), 16'd0);
    chk("after_req_ready", 16'(o_req_ready), 16'd1);
    chk("after_busy", 16'(o_busy), 16'd0);
    i_rsp_ready = 1'b0; i_req_valid = 1'b0; i_mfc = 1'b0;
  endtask
  initial begin
    i_rst_n = 1'b0; i_req_valid = 1'b0; i_req_we = 1'b0; i_rsp_ready = 1'b0; i_mfc = 1'b0;
    i_req_addr = '0; i_req_wdata = '0; i_mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 16'(o_req_ready), 16'd1);
    chk("rst_busy", 16'(o_busy), 16'd0);
    chk("rst_mem_en", 16'(o_mem_en), 16'd0);
    chk("rst_rsp_valid", 16'(o_rsp_valid), 16'd0);
    chk("rst_rsp_data", o_rsp_data, 16'h0);
    chk("rst_mem_addr", o_mem_addr, 16'h0);
    i_rst_n = 1'b1;
    i_mfc = 1'b1;
    @(negedge clk);
    chk("idle_mfc_ignored", 16'(o_busy), 16'd0);
    i_mfc = 1'b0;
    access(1'b0, 16'h0040, 16'h0000, 16'hBEEF, 0, 0, 0);
    access(1'b1, 16'h0010, 16'h1234, 16'h5555, 0, 2, 0);
    access(1'b0, 16'h0020, 16'h0000, 16'hA5A5, MR + 1, 0, 0);
    access(1'b0, 16'h0030, 16'h0000, 16'hC0DE, 1, 1, 0);
    access(1'b0, 16'h0050, 16'h0000, 16'h7E57, 0, 1, 5);
    access(1'b0, 16'h0060, 16'h0000, 16'h1111, MR, TO - 1, 1);
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 16'h0070;
    repeat (2) @(negedge clk);
    i_req_valid = 1'b0;
    chk("pre_rst_mem_en", 16'(o_mem_en), 16'd1);
    i_rst_n = 1'b0;
    #1;
    chk("async_mem_en", 16'(o_mem_en), 16'd0);
    chk("async_busy", 16'(o_busy), 16'd0);
    chk("async_rsp_valid", 16'(o_rsp_valid), 16'd0);
    chk("async_req_ready", 16'(o_req_ready), 16'd1);
    @(negedge clk);
    i_rst_n = 1'b1;
    access(1'b0, 16'h0080, 16'h0000, 16'h4321, 0, 0, 0);
    for (int n = 0; n < 20; n++)
      access(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             int'($urandom_range(0, MR + 1)), int'($urandom_range(0, TO - 1)), int'($urandom_range(0, 3)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
